axi_stream_burst_wr: RTL
========================

Name: axi_stream_burst_wr

Overview:
- Upstream feeder for the AXI-3 write helper: accepts a valid/ready word stream and packs it into INCR bursts of up to MAX_BURST_LEN beats.
- Drives the helper's enable/addr/data/burst_len interface and consumes its 2-bit status.
- Walks a linear buffer from a start address and never issues a burst that crosses a 4 KB boundary.
- Reports done, error and the number of words committed to the slave.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- BUS_WIDTH, 32, data beat width in bits; must be 8, 16, 32, 64 or 128.
- MAX_BURST_LEN, 16, maximum beats per burst, 1 to 16.
- COUNT_WIDTH, 16, width of word counters.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  start byte address; low log2(BUS_WIDTH/8) bits are forced to 0.
- total_words  in  COUNT_WIDTH  number of beats to write; sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of job (ok or error).
- error  out  1  set when a burst returns status 3; cleared on the next accepted start.
- words_written  out  COUNT_WIDTH  beats in bursts completed with status 2.
- s_data  in  BUS_WIDTH  stream data.
- s_valid  in  1  stream valid.
- s_ready  out  1  stream ready.
- wr_enable  out  1  one-cycle request to the write helper.
- wr_addr  out  ADDR_WIDTH  burst start address.
- wr_data  out  MAX_BURST_LEN*BUS_WIDTH  packed beats; beat i at bits [i*BUS_WIDTH +: BUS_WIDTH].
- wr_burst_len  out  4  beats minus 1.
- wr_burst_size  out  3  constant log2(BUS_WIDTH/8).
- wr_burst_type  out  2  constant 2'b01 (INCR).
- wr_strb  out  BUS_WIDTH/8  constant all ones.
- wr_status  in  2  helper status: 0 ready, 1 wait, 2 ok, 3 error; 2 and 3 last one cycle.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, error, s_ready, wr_enable = 0. words_written, wr_addr, wr_burst_len = 0. wr_data = 0.
- FSM states: IDLE, CALC, FILL, ISSUE, WAIT, FINISH.
- IDLE:
  - start=1 with total_words=0 -> FINISH, so done pulses on the 2nd cycle after start and no burst is issued.
  - start=1 otherwise -> latch cur_addr=base_addr (aligned), remaining=total_words; clear error and words_written; busy=1; -> CALC.
- CALC (1 cycle):
  - to_4k = (4096 - cur_addr[11:0]) >> log2(BUS_WIDTH/8).
  - beats = min(MAX_BURST_LEN, remaining, to_4k).
  - wr_burst_len = beats-1; wr_addr = cur_addr; fill index = 0; -> FILL.
- FILL:
  - s_ready=1; each s_valid&&s_ready stores s_data into beat[index] and increments index.
  - When the beat at index==wr_burst_len is accepted: s_ready drops in the same cycle's registered update (no further accept), -> ISSUE.
  - Unused upper beats of wr_data keep stale values (don't care).
- ISSUE:
  - Waits for wr_status==0, then asserts wr_enable for exactly one cycle -> WAIT.
  - wr_data, wr_addr and wr_burst_len are held stable from ISSUE until leaving WAIT.
- WAIT: ignores status 0/1.
  - Status 2: words_written += beats; remaining -= beats; cur_addr += beats*(BUS_WIDTH/8). If remaining==0 -> FINISH, else -> CALC.
  - Status 3: error=1; -> FINISH. The job aborts; no further stream words are accepted.
- FINISH: done=1 for one cycle; busy=0 on the following cycle; -> IDLE.
- s_ready is 0 in every state except FILL.
- start outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- A 4 KB split never shortens a burst below 1 beat, because the aligned address always leaves at least 1 beat before the boundary.
- Simultaneous events:
  - start and reset: reset wins.
  - s_valid held with s_ready=0: data is not consumed.

Test Plan:
- BUS_WIDTH 32, MAX 16, base 0x1000, total 16, s_valid always 1 -> one burst: wr_addr 0x1000, len 15, 16 consecutive accepts, words_written 16, done pulse, error 0.
- base 0x2000, total 37 -> bursts len 15/15/4 at 0x2000/0x2040/0x2080; words_written 37.
- base 0x0FF8, total 6 -> burst len 1 at 0x0FF8, then len 3 at 0x1000 (4 KB split).
- total 20, wr_status returns 3 on the first burst -> error=1, words_written 0, done pulse, s_ready stays 0 after the 16th accept.
- total 0 -> done on the 2nd cycle after start, wr_enable never asserted; s_valid toggling randomly during a 16-beat job -> beat order preserved in wr_data.
- Assert reset during WAIT -> all outputs return to reset values immediately; a new start afterwards completes normally.

Source files
------------

// File: rtl/axi_stream_burst_wr_if.sv
// Bundle of the word stream and the AXI-3 write-helper request/status lines
// used by axi_stream_burst_wr. The burst feeder is the master side.
//
// Handshake: a stream word transfers on a rising clock edge where s_valid and
// s_ready are both 1. The source holds s_data stable while s_valid is high and
// the word has not yet transferred. The helper request is a single-cycle
// wr_enable pulse, issued only while wr_status reads 0 (helper ready).
// Status 2 (ok) or 3 (error) then lasts exactly one cycle.
interface axi_stream_burst_wr_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 16
);
  logic [BUS_WIDTH-1:0]               s_data;
  logic                               s_valid;
  logic                               s_ready;
  logic                               wr_enable;
  logic [ADDR_WIDTH-1:0]              wr_addr;
  logic [MAX_BURST_LEN*BUS_WIDTH-1:0] wr_data;
  logic [3:0]                         wr_burst_len;
  logic [2:0]                         wr_burst_size;
  logic [1:0]                         wr_burst_type;
  logic [BUS_WIDTH/8-1:0]             wr_strb;
  logic [1:0]                         wr_status;

  modport master (
    input  s_data, s_valid, wr_status,
    output s_ready, wr_enable, wr_addr, wr_data, wr_burst_len,
           wr_burst_size, wr_burst_type, wr_strb
  );

  modport slave (
    output s_data, s_valid, wr_status,
    input  s_ready, wr_enable, wr_addr, wr_data, wr_burst_len,
           wr_burst_size, wr_burst_type, wr_strb
  );
endinterface

// File: rtl/axi_stream_burst_wr.sv
// Stream-to-burst feeder: packs a valid/ready word stream into INCR bursts of
// up to MAX_BURST_LEN beats. It walks a linear buffer from base_addr and never
// lets a burst cross a 4 KB boundary.
module axi_stream_burst_wr #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] total_words,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_written,
  output logic [2:0]             state_dbg,
  axi_stream_burst_wr_if.master  bus
);

  localparam int BYTES  = BUS_WIDTH / 8;
  localparam int SHIFT  = $clog2(BYTES);
  localparam int DATA_W = MAX_BURST_LEN * BUS_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_FILL   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [4:0]             beats_q;
  logic [3:0]             fill_idx;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [3:0]             wr_len_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic [COUNT_WIDTH-1:0] words_q;
  logic                   error_q;
  logic                   wr_en;

  // Beats left before the next 4 KB boundary. The address is always aligned,
  // so this is at least 1.
  logic [12:0] to_4k;
  logic [4:0]  rem_cap;
  logic [4:0]  room_cap;
  logic [4:0]  beats_calc;

  assign to_4k      = (13'd4096 - {1'b0, cur_addr[11:0]}) >> SHIFT;
  assign rem_cap    = (remaining >= COUNT_WIDTH'(MAX_BURST_LEN)) ? 5'(MAX_BURST_LEN) : remaining[4:0];
  assign room_cap   = (to_4k >= 13'(MAX_BURST_LEN)) ? 5'(MAX_BURST_LEN) : to_4k[4:0];
  assign beats_calc = (room_cap < rem_cap) ? room_cap : rem_cap;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and the single-cycle helper request.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (total_words == '0) ? ST_FINISH : ST_CALC;
      end
      ST_CALC:  state_nx = ST_FILL;
      ST_FILL: begin
        if (bus.s_valid && (fill_idx == wr_len_q)) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.wr_status == 2'd0) begin
          wr_en    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.wr_status == 2'd2)
          state_nx = (remaining == COUNT_WIDTH'(beats_q)) ? ST_FINISH : ST_CALC;
        else if (bus.wr_status == 2'd3)
          state_nx = ST_FINISH;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Job bookkeeping, burst sizing and beat packing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      beats_q   <= '0;
      fill_idx  <= '0;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr & ALIGN_MASK;
            remaining <= total_words;
            error_q   <= 1'b0;
            words_q   <= '0;
          end
        end
        ST_CALC: begin
          beats_q   <= beats_calc;
          wr_len_q  <= 4'(beats_calc - 5'd1);
          wr_addr_q <= cur_addr;
          fill_idx  <= '0;
        end
        ST_FILL: begin
          if (bus.s_valid) begin
            wr_data_q[int'(fill_idx)*BUS_WIDTH +: BUS_WIDTH] <= bus.s_data;
            fill_idx <= fill_idx + 4'd1;
          end
        end
        ST_WAIT: begin
          if (bus.wr_status == 2'd2) begin
            words_q   <= words_q + COUNT_WIDTH'(beats_q);
            remaining <= remaining - COUNT_WIDTH'(beats_q);
            cur_addr  <= cur_addr + (ADDR_WIDTH'(beats_q) << SHIFT);
          end else if (bus.wr_status == 2'd3) begin
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FINISH);
  assign error         = error_q;
  assign words_written = words_q;
  assign state_dbg     = state;

  assign bus.s_ready       = (state == ST_FILL);
  assign bus.wr_enable     = wr_en;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.wr_burst_len  = wr_len_q;
  assign bus.wr_burst_size = 3'(SHIFT);
  assign bus.wr_burst_type = 2'b01;
  assign bus.wr_strb       = '1;

endmodule
